// File: rtl/warp_issue_arbiter_pkg.sv
// Shared types and helpers for the warp issue unit.
package gpu_iu_pkg;

    localparam int NUM_WARPS_DEF = 8;
    localparam int MAX_WARPS     = 64;

    typedef enum logic [1:0] {
        IU_IDLE = 2'd0,
        IU_RUN  = 2'd1,
        IU_DONE = 2'd2
    } iu_state_e;

    // Callers must pass a one-hot (or zero) vector; zero maps to index 0.
    function automatic int unsigned onehot2idx(input logic [MAX_WARPS-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_WARPS; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/warp_issue_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit at or after prio, wrapping modulo N.
module rr_pick #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] prio,
    output logic [N-1:0] gnt
);

    logic         found;
    logic [W-1:0] idx;

    // N is a power of two, so W-bit addition wraps exactly at N.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = prio + W'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_issue_arbiter.sv
// Issue-unit scheduler: one issue grant and one exit grant per cycle, live-warp
// tracking and kernel-completion signalling.
module warp_issue_arbiter
    import gpu_iu_pkg::*;
#(
    parameter int NUM_WARPS = NUM_WARPS_DEF,
    parameter int WID_W     = $clog2(NUM_WARPS),
    parameter bit GREEDY    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start_IU,
    input  logic [NUM_WARPS-1:0] WarpMask_Start_IU,
    input  logic [NUM_WARPS-1:0] Req_IB_IU,
    output logic [NUM_WARPS-1:0] Grt_IU_IB,
    input  logic [NUM_WARPS-1:0] Exit_Req_IB_IU,
    output logic [NUM_WARPS-1:0] Exit_Grt_IU_IB,
    input  logic                 Stall_OC_IU,
    output logic                 Issue_Valid_IU_OC,
    output logic [WID_W-1:0]     WarpID_IU_OC,
    output logic                 Exit_Valid_IU_RAU,
    output logic [WID_W-1:0]     Exit_WarpID_IU_RAU,
    output logic [NUM_WARPS-1:0] ActiveWarps_IU,
    output logic                 Done_IU,
    output logic [15:0]          IssueCnt_IU
);

    iu_state_e            state_q, state_d;
    logic [NUM_WARPS-1:0] active_q, active_d;
    logic [WID_W-1:0]     prio_q, prio_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 exit_vld_q, exit_vld_d;
    logic [WID_W-1:0]     exit_wid_q, exit_wid_d;

    logic                 run;
    logic                 start_ok;
    logic [NUM_WARPS-1:0] exit_cand;
    logic [NUM_WARPS-1:0] exit_grt;
    logic [NUM_WARPS-1:0] elig;
    logic [NUM_WARPS-1:0] issue_grt;
    logic [WID_W-1:0]     issue_wid;
    logic [WID_W-1:0]     exit_wid;

    // Grants are suppressed combinationally while reset is asserted.
    assign run       = (state_q == IU_RUN) && rst;
    assign start_ok  = Start_IU && (|WarpMask_Start_IU);
    assign exit_cand = Exit_Req_IB_IU & active_q;
    assign exit_grt  = run ? (exit_cand & (~exit_cand + NUM_WARPS'(1))) : '0;
    assign elig      = (run && !Stall_OC_IU) ? (Req_IB_IU & active_q & ~exit_grt) : '0;

    rr_pick #(.N(NUM_WARPS), .W(WID_W)) u_issue_pick (
        .req  (elig),
        .prio (prio_q),
        .gnt  (issue_grt)
    );

    assign issue_wid = WID_W'(onehot2idx(MAX_WARPS'(issue_grt)));
    assign exit_wid  = WID_W'(onehot2idx(MAX_WARPS'(exit_grt)));

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        prio_d     = prio_q;
        cnt_d      = cnt_q;
        exit_vld_d = 1'b0;
        exit_wid_d = exit_wid_q;
        case (state_q)
            IU_IDLE, IU_DONE: begin
                if (start_ok) begin
                    state_d  = IU_RUN;
                    active_d = WarpMask_Start_IU;
                    prio_d   = '0;
                    cnt_d    = '0;
                end
            end
            IU_RUN: begin
                active_d = active_q & ~exit_grt;
                if (|exit_grt) begin
                    exit_vld_d = 1'b1;
                    exit_wid_d = exit_wid;
                end
                if (|issue_grt) begin
                    cnt_d  = cnt_q + 16'd1;
                    prio_d = GREEDY ? issue_wid : issue_wid + WID_W'(1);
                end
                if (active_d == '0) state_d = IU_DONE;
            end
            default: state_d = IU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IU_IDLE;
            active_q   <= '0;
            prio_q     <= '0;
            cnt_q      <= '0;
            exit_vld_q <= 1'b0;
            exit_wid_q <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            prio_q     <= prio_d;
            cnt_q      <= cnt_d;
            exit_vld_q <= exit_vld_d;
            exit_wid_q <= exit_wid_d;
        end
    end

    assign Grt_IU_IB          = issue_grt;
    assign Exit_Grt_IU_IB     = exit_grt;
    assign Issue_Valid_IU_OC  = |issue_grt;
    assign WarpID_IU_OC       = issue_wid;
    assign Exit_Valid_IU_RAU  = exit_vld_q;
    assign Exit_WarpID_IU_RAU = exit_wid_q;
    assign ActiveWarps_IU     = active_q;
    assign Done_IU            = (state_q == IU_DONE);
    assign IssueCnt_IU        = cnt_q;

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Directed bench for warp_issue_arbiter: round-robin instance plus a greedy instance.
module tb_warp_issue_arbiter;

    logic       clk;
    logic       rst, start, stall;
    logic [7:0] mask, req, xreq;
    logic [7:0] grt, xgrt, active;
    logic       ivld, xvld, done;
    logic [2:0] wid, xwid;
    logic [15:0] cnt;

    logic       g_rst, g_start, g_stall;
    logic [7:0] g_mask, g_req, g_xreq;
    logic [7:0] g_grt, g_xgrt, g_active;
    logic       g_ivld, g_xvld, g_done;
    logic [2:0] g_wid, g_xwid;
    logic [15:0] g_cnt;

    int checks = 0;
    int errors = 0;

    warp_issue_arbiter #(.NUM_WARPS(8), .WID_W(3), .GREEDY(1'b0)) dut (
        .clk(clk), .rst(rst), .Start_IU(start), .WarpMask_Start_IU(mask),
        .Req_IB_IU(req), .Grt_IU_IB(grt), .Exit_Req_IB_IU(xreq), .Exit_Grt_IU_IB(xgrt),
        .Stall_OC_IU(stall), .Issue_Valid_IU_OC(ivld), .WarpID_IU_OC(wid),
        .Exit_Valid_IU_RAU(xvld), .Exit_WarpID_IU_RAU(xwid), .ActiveWarps_IU(active),
        .Done_IU(done), .IssueCnt_IU(cnt)
    );

    warp_issue_arbiter #(.NUM_WARPS(8), .WID_W(3), .GREEDY(1'b1)) dut_g (
        .clk(clk), .rst(g_rst), .Start_IU(g_start), .WarpMask_Start_IU(g_mask),
        .Req_IB_IU(g_req), .Grt_IU_IB(g_grt), .Exit_Req_IB_IU(g_xreq), .Exit_Grt_IU_IB(g_xgrt),
        .Stall_OC_IU(g_stall), .Issue_Valid_IU_OC(g_ivld), .WarpID_IU_OC(g_wid),
        .Exit_Valid_IU_RAU(g_xvld), .Exit_WarpID_IU_RAU(g_xwid), .ActiveWarps_IU(g_active),
        .Done_IU(g_done), .IssueCnt_IU(g_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stall = 1'b0; mask = 8'h00; req = 8'hFF; xreq = 8'h00;
        g_rst = 1'b0; g_start = 1'b0; g_stall = 1'b0; g_mask = 8'h00; g_req = 8'h00; g_xreq = 8'h00;
        step(); step();
        settle();
        chk("rst_grt", grt, 8'h00);
        chk("rst_active", active, 8'h00);
        chk("rst_cnt", cnt, 16'd0);
        chk("rst_xvld", xvld, 1'b0);
        chk("rst_done", done, 1'b0);

        rst = 1'b1; g_rst = 1'b1; req = 8'h05;
        settle();
        chk("idle_grt", grt, 8'h00);
        start = 1'b1; mask = 8'h0F;
        step();
        // Test 1: loose round-robin over warps 0 and 2.
        start = 1'b0; mask = 8'h00;
        settle();
        chk("t1_active", active, 8'h0F);
        chk("t1_grt0", grt, 8'h01);
        chk("t1_wid0", wid, 3'd0);
        chk("t1_cnt0", cnt, 16'd0);
        step();
        chk("t1_grt1", grt, 8'h04);
        chk("t1_wid1", wid, 3'd2);
        chk("t1_cnt1", cnt, 16'd1);
        step();
        chk("t1_grt2", grt, 8'h01);
        chk("t1_cnt2", cnt, 16'd2);
        step();

        // Test 2: stall freezes prio (now 1) and the issue count (now 3).
        req = 8'hFF; stall = 1'b1;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("t2_stall_grt", grt, 8'h00);
            chk("t2_stall_vld", ivld, 1'b0);
            chk("t2_stall_cnt", cnt, 16'd3);
            step();
        end
        stall = 1'b0;
        settle();
        chk("t2_resume_grt", grt, 8'h02);
        chk("t2_resume_wid", wid, 3'd1);
        step();

        // Test 3: concurrent exit and issue; then same-warp conflict.
        req = 8'h01; xreq = 8'h06;
        settle();
        chk("t3_xgrt", xgrt, 8'h02);
        chk("t3_grt", grt, 8'h01);
        step();
        req = 8'h04;
        settle();
        chk("t3_active", active, 8'h0D);
        chk("t3_xvld", xvld, 1'b1);
        chk("t3_xwid", xwid, 3'd1);
        chk("t3_cnt", cnt, 16'd5);
        chk("t3_xgrt2", xgrt, 8'h04);
        chk("t3_conflict_grt", grt, 8'h00);
        step();

        // Test 4: drain the remaining warps 0 and 3.
        req = 8'h00; xreq = 8'h09;
        settle();
        chk("t4_xvld", xvld, 1'b1);
        chk("t4_xwid", xwid, 3'd2);
        chk("t4_active", active, 8'h09);
        chk("t4_cnt", cnt, 16'd5);
        chk("t4_xgrt0", xgrt, 8'h01);
        step();
        chk("t4_xgrt3", xgrt, 8'h08);
        chk("t4_done_early", done, 1'b0);
        step();
        xreq = 8'h00; req = 8'hFF;
        settle();
        chk("t4_done", done, 1'b1);
        chk("t4_active0", active, 8'h00);
        chk("t4_xwid3", xwid, 3'd3);
        chk("t4_done_grt", grt, 8'h00);
        start = 1'b1; mask = 8'h00;
        step();
        chk("t4_zero_mask", done, 1'b1);
        mask = 8'h03;
        step();
        chk("t4_restart_done", done, 1'b0);
        chk("t4_restart_cnt", cnt, 16'd0);
        chk("t4_restart_active", active, 8'h03);
        mask = 8'hFF;
        settle();
        chk("t4_restart_grt", grt, 8'h01);
        step();
        start = 1'b0; mask = 8'h00;
        settle();
        chk("t4_start_ignored", active, 8'h03);
        chk("t4_cnt1", cnt, 16'd1);

        // Test 6: reset mid-run kills grants in the same cycle.
        rst = 1'b0; xreq = 8'h01;
        settle();
        chk("t6_grt", grt, 8'h00);
        chk("t6_xgrt", xgrt, 8'h00);
        step();
        rst = 1'b1; xreq = 8'h00;
        settle();
        chk("t6_active", active, 8'h00);
        chk("t6_cnt", cnt, 16'd0);
        chk("t6_xvld", xvld, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_idle_grt", grt, 8'h00);

        // Inactive warp requests are never granted.
        start = 1'b1; mask = 8'h01; req = 8'h80;
        step();
        start = 1'b0; mask = 8'h00;
        settle();
        chk("t5_inactive_grt", grt, 8'h00);
        chk("t5_inactive_vld", ivld, 1'b0);

        // Test 5: greedy instance sticks with warp 0 while it requests.
        g_start = 1'b1; g_mask = 8'h0F; g_req = 8'h03;
        step();
        g_start = 1'b0; g_mask = 8'h00;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("t5_greedy_grt", g_grt, 8'h01);
            step();
        end
        chk("t5_greedy_cnt", g_cnt, 16'd3);
        g_req = 8'h02;
        settle();
        chk("t5_greedy_drop", g_grt, 8'h02);
        step();
        g_req = 8'h03;
        settle();
        chk("t5_greedy_stick", g_grt, 8'h02);
        chk("t5_greedy_wid", g_wid, 3'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
